// File: rtl/o_bram_writeback_pkg.sv
// o_bram_writeback shared types and constants.
// FSM state encoding and BRAM word/byte geometry.
package owb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam int BRAM_BYTES_PER_WORD = 4;
  localparam logic [BRAM_BYTES_PER_WORD-1:0] WE_ALL = 4'hF;
  localparam int BYTE_ADDR_SHIFT = 2;

endpackage

// File: rtl/o_bram_writeback_if.sv
// Row stream from the matmul result path plus the O_BRAM write port.
// slave = writeback block, master = row source / BRAM side.
interface o_bram_writeback_if
  import owb_pkg::*;
#(
  parameter int ARRAY_M      = 8,
  parameter int PE_OUT_WIDTH = 32
) ();

  logic                            row_valid;
  logic                            row_ready;
  logic [PE_OUT_WIDTH*ARRAY_M-1:0] row_data;

  logic [31:0]                     ext_addr_o_bram;
  logic                            enable_o_bram;
  logic [BRAM_BYTES_PER_WORD-1:0]  w_enable_o_bram;
  logic [31:0]                     data_in_o_bram;

  modport slave (
    input  row_valid,
    input  row_data,
    output row_ready,
    output ext_addr_o_bram,
    output enable_o_bram,
    output w_enable_o_bram,
    output data_in_o_bram
  );

  modport master (
    output row_valid,
    output row_data,
    input  row_ready,
    input  ext_addr_o_bram,
    input  enable_o_bram,
    input  w_enable_o_bram,
    input  data_in_o_bram
  );

endinterface

// File: rtl/o_bram_writeback_row_fifo.sv
// owb_row_fifo: small synchronous row FIFO with async active-low reset.
// A push into a full FIFO is taken only when a pop frees the slot.
module owb_row_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/o_bram_writeback.sv
// o_bram_writeback: drains result rows into O_BRAM, one word per cycle.
// Define OWB_RELU_EN to clamp negative elements to zero on write.
module o_bram_writeback
  import owb_pkg::*;
#(
  parameter int ARRAY_N      = 8,
  parameter int ARRAY_M      = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [$clog2(ARRAY_N):0] num_rows,
  input  logic [$clog2(ARRAY_M):0] num_cols,
  output logic                    busy,
  output logic                    done,
  o_bram_writeback_if.slave       bus
);

  localparam int RW  = $clog2(ARRAY_N) + 1;
  localparam int CW  = $clog2(ARRAY_M) + 1;
  localparam int CIW = $clog2(ARRAY_M);
  localparam int DW  = PE_OUT_WIDTH * ARRAY_M;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [RW-1:0]           nrows_q;
  logic [CW-1:0]           ncols_q;
  logic [RW-1:0]           rows_acc;
  logic [RW-1:0]           rows_wr;
  logic [CIW-1:0]          col;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [DW-1:0]           head;
  logic [ARRAY_M-1:0][PE_OUT_WIDTH-1:0] head_v;
  logic [PE_OUT_WIDTH-1:0] elem;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign bus.row_ready = (state == RUN) && !full
                       && (rows_acc < nrows_q);
  assign push = bus.row_valid && bus.row_ready;
  assign pop  = !empty && (CW'(col) == ncols_q - CW'(1));

  assign head_v = head;

  always_comb begin
    elem = head_v[col];
`ifdef OWB_RELU_EN
    if (elem[PE_OUT_WIDTH-1]) elem = '0;
`endif
  end

  // Row stride is ARRAY_M words; the sum wraps at 2^ADDR_WIDTH.
  assign word_addr = base_q
                   + ADDR_WIDTH'(rows_wr * ARRAY_M)
                   + ADDR_WIDTH'(col);

  owb_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (bus.row_data),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      base_q              <= '0;
      nrows_q             <= RW'(1);
      ncols_q             <= CW'(1);
      rows_acc            <= '0;
      rows_wr             <= '0;
      col                 <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      bus.enable_o_bram   <= 1'b0;
      bus.w_enable_o_bram <= '0;
      bus.ext_addr_o_bram <= '0;
      bus.data_in_o_bram  <= '0;
    end else begin
      done                <= 1'b0;
      bus.enable_o_bram   <= 1'b0;
      bus.w_enable_o_bram <= '0;
      bus.ext_addr_o_bram <= '0;
      bus.data_in_o_bram  <= '0;

      if (push) rows_acc <= rows_acc + RW'(1);

      if (!empty) begin
        bus.enable_o_bram   <= 1'b1;
        bus.w_enable_o_bram <= WE_ALL;
        bus.ext_addr_o_bram <= 32'(word_addr) << BYTE_ADDR_SHIFT;
        bus.data_in_o_bram  <= elem;
        if (pop) begin
          col     <= '0;
          rows_wr <= rows_wr + RW'(1);
        end else begin
          col <= col + CIW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            nrows_q  <= (num_rows == '0) ? RW'(1) : num_rows;
            ncols_q  <= (num_cols == '0) ? CW'(1) : num_cols;
            rows_acc <= '0;
            rows_wr  <= '0;
            col      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (rows_acc == nrows_q) state <= FLUSH;
        end
        FLUSH: begin
          if (empty && rows_wr == nrows_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_o_bram_writeback.sv
// Directed bench for o_bram_writeback with an expected-write scoreboard.
// Honours OWB_RELU_EN in its data model.
module tb_o_bram_writeback;

  localparam int N  = 8;
  localparam int M  = 8;
  localparam int W  = 32;
  localparam int AW = 10;
  localparam int D  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [3:0]    num_rows = '0;
  logic [3:0]    num_cols = '0;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  wr_t            sb[$];
  logic [W*M-1:0] rows [N];
  logic [31:0]    relu_row [M];

  o_bram_writeback_if #(.ARRAY_M(M), .PE_OUT_WIDTH(W)) bus ();

  o_bram_writeback #(
    .ARRAY_N      (N),
    .ARRAY_M      (M),
    .PE_OUT_WIDTH (W),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .num_cols  (num_cols),
    .busy      (busy),
    .done      (done),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xform(input logic [31:0] v);
`ifdef OWB_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_en"},   32'(bus.enable_o_bram), 32'h0);
    chk({tag, "_we"},   32'(bus.w_enable_o_bram), 32'h0);
    chk({tag, "_addr"}, bus.ext_addr_o_bram, 32'h0);
    chk({tag, "_data"}, bus.data_in_o_bram, 32'h0);
  endtask

  task automatic push_row(input logic [AW-1:0] base,
                          input int r, input int nc);
    wr_t e;
    logic [AW-1:0] wa;
    for (int j = 0; j < nc; j++) begin
      wa = base + AW'(r * M + j);
      e.addr = {20'h0, wa, 2'b00};
      e.data = xform(rows[r][j*32 +: 32]);
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] base,
                         input int nr_in, input int nc_in,
                         input int abort_at);
    int  nr, nc, r, k, wcnt, first, last, occ;
    bit  acc, fin, aborted;
    wr_t e;
    nr = (nr_in == 0) ? 1 : nr_in;
    nc = (nc_in == 0) ? 1 : nc_in;
    r = 0; wcnt = 0; first = -1; last = -1;
    fin = 1'b0; aborted = 1'b0; acc = 1'b0;
    sb.delete();
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    num_rows = 4'(nr_in);
    num_cols = 4'(nc_in);
    bus.row_valid = 1'b1;
    bus.row_data = rows[0];
    @(negedge clk);
    start = 1'b0;
    base_addr = ~base;
    num_rows = 4'd2;
    num_cols = 4'd3;
    chk("busy_rise", 32'(busy), 32'h1);
    for (k = 0; k < 400; k++) begin
      if (bus.enable_o_bram) begin
        if (sb.size() == 0) begin
          chk("extra_write", 32'(sb.size()), 32'h1);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", bus.ext_addr_o_bram, e.addr);
          chk("wr_data", bus.data_in_o_bram, e.data);
          chk("wr_we", 32'(bus.w_enable_o_bram), 32'hF);
        end
        wcnt++;
        if (first < 0) first = k;
        last = k;
      end else begin
        chk_outputs_zero("idle");
      end
      if (abort_at > 0 && wcnt == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ready", 32'(bus.row_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
      occ = r - wcnt / nc;
      chk("row_ready", 32'(bus.row_ready),
          32'(occ < D && r < nr));
      acc = bus.row_ready && bus.row_valid;
      if (acc) push_row(base, r, nc);
      if (k == 4) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (acc) begin
        r++;
        if (r < nr) bus.row_data = rows[r];
      end
    end
    bus.row_valid = 1'b0;
    if (!aborted) begin
      chk("done_seen", 32'(fin), 32'h1);
      chk("done_cycle", 32'(k), 32'(2 + nr * nc));
      chk("busy_fall", 32'(busy), 32'h0);
      chk("write_count", 32'(wcnt), 32'(nr * nc));
      chk("no_bubble", 32'(last - first + 1), 32'(nr * nc));
      chk("sb_drained", 32'(sb.size()), 32'h0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'h0);
      chk("post_ready", 32'(bus.row_ready), 32'h0);
    end
    sb.delete();
  endtask

  task automatic fill_rows();
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < M; j++) begin
        rows[r][j*32 +: 32] = 32'(r * 16 + j);
      end
    end
  endtask

  initial begin
    bus.row_valid = 1'b0;
    bus.row_data = '0;
    relu_row = '{32'hFFFF_FFFB, 32'h7, 32'h8000_0000, 32'h1,
                 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h2A};
    fill_rows();
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst");
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(bus.row_ready), 32'h0);
    reset_n = 1'b1;
    bus.row_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.row_ready), 32'h0);
    bus.row_valid = 1'b0;

    run_job(10'h040, 8, 8, 0);
    run_job(10'h000, 3, 5, 0);
    run_job(10'h3FC, 1, 8, 0);

    for (int j = 0; j < M; j++) rows[0][j*32 +: 32] = relu_row[j];
    run_job(10'h100, 1, 8, 0);
    fill_rows();
    run_job(10'h200, 0, 0, 0);

    run_job(10'h040, 8, 8, 10);
    run_job(10'h040, 8, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/o_bram_writeback.md
# o_bram_writeback

Drains result rows produced by the systolic matrix-multiply system and serialises them into the output BRAM as one 32-bit element per write. It sits directly downstream of the matmul system's result path and owns the O_BRAM write port: address, enable, byte-write-enable and data. A two-entry row FIFO decouples the array's drain from the one-word-per-cycle BRAM write rate.

## Interface
- ARRAY_N, 8, maximum result rows per job
- ARRAY_M, 8, elements per result row (row stride in BRAM words)
- PE_OUT_WIDTH, 32, element width; must equal 32 (one element per BRAM word)
- ADDR_WIDTH, 10, word-address width of base_addr
- FIFO_DEPTH, 2, row FIFO entries; power of two, ≥2

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job launch; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  word address of element (0,0)
- num_rows  in  $clog2(ARRAY_N)+1  rows in job, 1..ARRAY_N
- num_cols  in  $clog2(ARRAY_M)+1  valid elements per row, 1..ARRAY_M
- row_valid  in  1  upstream row present
- row_ready  out  1  block accepts row this cycle
- row_data  in  PE_OUT_WIDTH*ARRAY_M  row; element j at bits [32j+31:32j]
- ext_addr_o_bram  out  32  byte address = word address << 2
- enable_o_bram  out  1  BRAM port enable
- w_enable_o_bram  out  4  byte write enables
- data_in_o_bram  out  32  write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final write

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: busy=0, row_ready=0. Start latches base_addr, num_rows and num_cols. It clears the row counters and moves to RUN. A num_rows or num_cols value of 0 is treated as 1.
- RUN: row_ready = !fifo_full && (rows_accepted < num_rows). A row is accepted on row_valid && row_ready and pushed to the FIFO.
- Writer: while the FIFO is non-empty it writes one element per cycle from the head row, col = 0..num_cols-1. On col = num_cols-1 it pops the head and increments rows_written.
- Write address (word) = base_addr + rows_written*ARRAY_M + col. Addition is modulo 2^ADDR_WIDTH and wraps silently. ext_addr_o_bram = {zeros, word_addr, 2'b00}.
- During a write: enable_o_bram=1, w_enable_o_bram=4'hF. Otherwise all three BRAM outputs and the data output are 0.
- When rows_accepted == num_rows, go to FLUSH. FLUSH continues the writer until the FIFO is empty and rows_written == num_rows, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle done rises.
- start while busy is ignored. row_valid outside RUN is ignored; no row is consumed.
- Push and pop in the same cycle with a full FIFO is allowed. The pop frees the slot, and row_ready is computed from the pre-pop full flag.

## Timing
- Reset values: row_ready=0, enable_o_bram=0, w_enable_o_bram=0, ext_addr_o_bram=0, data_in_o_bram=0, busy=0, done=0, state=IDLE, FIFO empty.
- All BRAM outputs are registered.
- A row accepted at edge t into an empty FIFO produces its first write at cycle t+1. The next row's first write directly follows the previous row's last write, with no bubble.
- Steady-state throughput is num_cols cycles per row.
- Job length with upstream always valid: 1 (start) + num_rows*num_cols + 1 cycles to the done pulse.
- Asserting reset_n low mid-job aborts immediately. In-flight data is dropped and outputs return to reset values asynchronously.

## Configuration
- OWB_RELU_EN defined: each element is treated as signed. Negative values are written as 32'h0, and non-negative values pass unchanged.
- OWB_RELU_EN undefined: elements are written bit-exact.

## Structure
- Package owb_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - BRAM_BYTES_PER_WORD=4
  - WE_ALL=4'hF
  - BYTE_ADDR_SHIFT=2
- One sub-module, owb_row_fifo. It is a FIFO_DEPTH x (PE_OUT_WIDTH*ARRAY_M) synchronous FIFO with push, pop, full, empty, head and async active-low reset.
- The top level contains the FSM, counters, address generation and output registers.

## Test plan
- Single job, 8x8, base_addr=0x040, rows with element(r,j)=r*16+j, row_valid held high:
  - expect 64 writes at byte addresses 0x100..0x1FC, in order, with data equal to the element values;
  - w_enable=F on every write;
  - done exactly 66 cycles after start.
- num_rows=3, num_cols=5, base_addr=0:
  - expect writes only at word addresses 0-4, 8-12 and 16-20;
  - done after 15 writes;
  - row_ready deasserts after the third row is accepted.
- Backpressure: row_valid is asserted continuously and row_ready is checked while the FIFO holds 2 rows.
  - row_ready must be 0 while the FIFO is full;
  - no row may be lost or duplicated;
  - BRAM writes must be back-to-back with no idle cycle between rows.
- Wrap: base_addr=0x3FC, ADDR_WIDTH=10, 1x8 job -> word addresses 0x3FC..0x3FF then 0x000..0x003.
- With OWB_RELU_EN, row {-5, 7, 0x80000000, 1, ...} -> writes 0, 7, 0, 1, ...; without the macro the values are written unchanged.
- Pulse reset_n low after 10 writes of an 8x8 job:
  - all outputs go to 0 immediately and busy=0;
  - a new start then completes a full job normally.
